// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared widths and the writeback request payload used by the
//                writeback arbiter and its source-B FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Small synchronous FIFO holding source-B writeback requests.
//                Ports:
//                  clk, rst        clock, synchronous active-high reset
//                  push_i/push_data_i  enqueue (ignored while full)
//                  pop_i           dequeue head (ignored while empty)
//                  head_o          current head entry
//                  full_o/empty_o  occupancy flags
//                  count_o         number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  wb_req_t                  push_data_i,
  input  logic                     pop_i,
  output wb_req_t                  head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  wb_req_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;
  logic            w_push;
  logic            w_pop;

  assign full_o  = (count_q == c_depth);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i  && !empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: an entry is only read once counted.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Merges the ALU result stream (A, priority) and buffered
//                long-latency results (B) onto the single register-file
//                write port, with a starvation guard that stalls A so a
//                waiting B entry is eventually written.
//                Ports:
//                  clk, rst                  clock, synchronous reset
//                  a_valid/a_ready/a_rd/a_data   source A handshake+payload
//                  b_valid/b_ready/b_rd/b_data   source B handshake+payload
//                  rf_wen/rf_wa/rf_wd        registered write port
//                  b_pending                 source-B FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [REG_AW-1:0]       a_rd,
  input  logic [XLEN-1:0]         a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [REG_AW-1:0]       b_rd,
  input  logic [XLEN-1:0]         b_data,
  output logic                    rf_wen,
  output logic [REG_AW-1:0]       rf_wa,
  output logic [XLEN-1:0]         rf_wd,
  output logic [$clog2(DEPTH):0]  b_pending
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_MAX);

  wb_req_t            w_head;
  wb_req_t            w_push_data;
  logic               w_full;
  logic               w_empty;
  logic               w_force_b;
  logic               w_grant_a;
  logic               w_grant_b;

  logic [SW-1:0]      starve_q, starve_d;
  logic               wen_q,    wen_d;
  logic [REG_AW-1:0]  wa_q,     wa_d;
  logic [XLEN-1:0]    wd_q,     wd_d;

  assign w_push_data.rd   = b_rd;
  assign w_push_data.data = b_data;

  // Readiness looks at "full" only; a same-cycle pop does not open a slot.
  assign b_ready = !rst && !w_full;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (b_valid && b_ready),
    .push_data_i (w_push_data),
    .pop_i       (w_grant_b),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (b_pending)
  );

  // Once B has waited STARVE_MAX cycles, A is held off for one cycle,
  // which hands the write port to the FIFO head.
  always_comb begin
    w_force_b = !w_empty && (starve_q == c_starve_max);
    a_ready   = !rst && !w_force_b;
    w_grant_a = a_valid && a_ready;
    w_grant_b = !rst && !w_empty && !w_grant_a;
  end

  always_comb begin
    starve_d = '0;
    if (!w_empty && !w_grant_b) begin
      starve_d = (starve_q == c_starve_max) ? starve_q : starve_q + 1'b1;
    end
  end

  // Writes to x0 still consume the request but never raise the enable.
  always_comb begin
    wen_d = 1'b0;
    wa_d  = wa_q;
    wd_d  = wd_q;
    if (w_grant_a) begin
      wen_d = (a_rd != '0);
      wa_d  = a_rd;
      wd_d  = a_data;
    end else if (w_grant_b) begin
      wen_d = (w_head.rd != '0);
      wa_d  = w_head.rd;
      wd_d  = w_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      wen_q    <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      starve_q <= starve_d;
      wen_q    <= wen_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign rf_wen = wen_q;
  assign rf_wa  = wa_q;
  assign rf_wd  = wd_q;

endmodule : writeback_arbiter
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_arbiter
//  Description : Self-checking bench for writeback_arbiter. Directed steps
//                followed by random traffic, all compared against a
//                queue-based reference model of the writeback rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;
  localparam int PW         = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready;
  logic [4:0]    a_rd;
  logic [31:0]   a_data;
  logic          b_valid, b_ready;
  logic [4:0]    b_rd;
  logic [31:0]   b_data;
  logic          rf_wen;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;
  logic [PW-1:0] b_pending;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .rf_wen    (rf_wen),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .b_pending (b_pending)
  );

  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: B queue, cycles the head has waited, expected port.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        bq[$];
  int          starve = 0;
  logic        m_wen  = 1'b0;
  logic [4:0]  m_wa   = '0;
  logic [31:0] m_wd   = '0;
  logic        s_ar, s_br;

  // One clock: check handshake outputs mid-cycle, advance the model across
  // the rising edge, then check the registered write port.
  task automatic step();
    logic e_ar, e_br;
    bit   ga, gb, pushed;
    int   sz;
    ent_t h;
    @(negedge clk);
    sz   = bq.size();
    e_ar = !rst && !(sz > 0 && starve == STARVE_MAX);
    e_br = !rst && (sz < DEPTH);
    s_ar = a_ready;
    s_br = b_ready;
    chk("a_ready",   32'(a_ready),   32'(e_ar));
    chk("b_ready",   32'(b_ready),   32'(e_br));
    chk("b_pending", 32'(b_pending), 32'(sz));
    @(posedge clk);
    #1;
    if (rst) begin
      bq.delete();
      starve = 0;
      m_wen  = 1'b0;
      m_wa   = '0;
      m_wd   = '0;
    end else begin
      ga     = a_valid && e_ar;
      gb     = (sz > 0) && !ga;
      pushed = b_valid && e_br;
      if (ga) begin
        m_wen = (a_rd != 0);
        m_wa  = a_rd;
        m_wd  = a_data;
      end else if (gb) begin
        h     = bq.pop_front();
        m_wen = (h.rd != 0);
        m_wa  = h.rd;
        m_wd  = h.data;
      end else begin
        m_wen = 1'b0;
      end
      if (sz > 0 && !gb) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
      else               starve = 0;
      if (pushed) bq.push_back('{rd: b_rd, data: b_data});
    end
    chk("rf_wen", 32'(rf_wen), 32'(m_wen));
    chk("rf_wa",  32'(rf_wa),  32'(m_wa));
    chk("rf_wd",  rf_wd,       m_wd);
  endtask

  initial begin
    rst     = 1'b1;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;

    // Reset held two cycles.
    step();
    step();
    chk("rst_wen",     32'(rf_wen),    32'd0);
    chk("rst_pending", 32'(b_pending), 32'd0);
    chk("rst_a_ready", 32'(s_ar),      32'd0);
    chk("rst_b_ready", 32'(s_br),      32'd0);
    rst = 1'b0;
    step();
    chk("rel_a_ready", 32'(s_ar), 32'd1);
    chk("rel_b_ready", 32'(s_br), 32'd1);

    // A alone.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    step();
    a_valid = 1'b0;
    chk("a_wen", 32'(rf_wen), 32'd1);
    chk("a_wa",  32'(rf_wa),  32'd5);
    chk("a_wd",  rf_wd,       32'hDEADBEEF);
    step();
    chk("a_wen_drop", 32'(rf_wen), 32'd0);

    // B alone: pending after one edge, written after two.
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h12345678;
    step();
    b_valid = 1'b0;
    chk("b_pend1", 32'(b_pending), 32'd1);
    chk("b_wen_early", 32'(rf_wen), 32'd0);
    step();
    chk("b_wen", 32'(rf_wen), 32'd1);
    chk("b_wa",  32'(rf_wa),  32'd7);
    chk("b_pend0", 32'(b_pending), 32'd0);

    // x0 from both sources: handshakes complete, no write enable.
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFFFFFF;
    step();
    a_valid = 1'b0;
    chk("x0_a_wen", 32'(rf_wen), 32'd0);
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFFFFFF;
    step();
    b_valid = 1'b0;
    chk("x0_b_acc", 32'(s_br), 32'd1);
    step();
    chk("x0_b_wen", 32'(rf_wen),    32'd0);
    chk("x0_b_pop", 32'(b_pending), 32'd0);

    // Starvation: A saturates, one B entry is forced through.
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h0000_1111;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h0000_9999;
    step();
    b_valid = 1'b0;
    for (int i = 0; i < STARVE_MAX; i++) begin
      step();
      chk("starve_a_win", 32'(rf_wa), 32'd1);
    end
    step();
    chk("starve_a_block", 32'(s_ar),  32'd0);
    chk("starve_b_wa",    32'(rf_wa), 32'd9);
    step();
    chk("starve_a_back", 32'(s_ar),  32'd1);
    chk("starve_a_wa",   32'(rf_wa), 32'd1);

    // Full FIFO, then reset with entries queued.
    a_rd = 5'd3; a_data = 32'h0000_3333;
    b_valid = 1'b1; b_rd = 5'd20; b_data = 32'hA000_0020;
    step();
    b_rd = 5'd21; b_data = 32'hA000_0021;
    step();
    b_rd = 5'd22; b_data = 32'hA000_0022;
    step();
    chk("full_b_ready", 32'(s_br),      32'd0);
    chk("full_pending", 32'(b_pending), 32'd2);
    rst = 1'b1;
    step();
    chk("mrst_pending", 32'(b_pending), 32'd0);
    chk("mrst_wen",     32'(rf_wen),    32'd0);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_stale_b", 32'(rf_wen && rf_wa >= 5'd20 && rf_wa <= 5'd22), 32'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      a_valid = ($urandom_range(0, 2) != 0);
      a_rd    = 5'($urandom_range(0, 31));
      a_data  = $urandom;
      b_valid = ($urandom_range(0, 1) == 1);
      b_rd    = 5'($urandom_range(0, 31));
      b_data  = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule : tb_writeback_arbiter
`default_nettype wire
